matrix_scan: RTL and testbench
==============================

// Module: matrix_scan
// PURPOSE
//  Reader/consumer of the 8x16 snake pixel register written by the game's pixel generator.
//  Snapshots the frame at each frame start (no tearing). Refreshes the LED matrix row by row:
//  serialises one row's 16 column bits into an external 74HC595-style chain, latches them,
//  enables that row for a dwell time, then moves on. Pulses frame_done so game logic can pace updates.
// PARAMETERS
//  ROWS     8    matrix rows; row r = pixelReg[COLS*r +: COLS]
//  COLS     16   columns per row = bits shifted per row
//  CLK_DIV  2    clk cycles per sr_clk half-period; also latch pulse width (>=1)
//  DWELL    100  clk cycles a row stays enabled (>=1)
// PORTS
//  clk        in   1          system clock; all logic on posedge
//  init       in   1          synchronous, active-high reset
//  en         in   1          scan enable; sampled only at the frame boundary
//  pixelReg   in   ROWS*COLS  framebuffer; bit 0 = lit, 1 = dark
//  sr_data    out  1          serial column data; pixel bit passed through unchanged (active-low sink)
//  sr_clk     out  1          shift clock; chain samples sr_data on the rising edge
//  sr_latch   out  1          storage-register latch pulse, active high
//  row_sel    out  ROWS       one-hot row enable, active high; all-zero = blanked
//  frame_done out  1          1-cycle pulse at end of last row's dwell
// BEHAVIOUR
//  Reset (init=1 at posedge): state=LOAD, row=0. Outputs next cycle: sr_data=1, sr_clk=0,
//    sr_latch=0, row_sel=0, frame_done=0. Applies in any state, including mid-SHIFT.
//  FSM: LOAD -> SHIFT -> LATCH -> DWELL -> LOAD.
//  LOAD (1 cycle): if row==0 and en==0, stay in LOAD, outputs idle.
//    If row==0 and en==1, copy pixelReg into frame buffer fb.
//    Rows 1..ROWS-1 never copy; they read fb.
//  SHIFT: COLS bits, MSB first (col COLS-1 first, col 0 last).
//    Per bit: sr_data = fb[row][col] with sr_clk=0 for CLK_DIV cycles,
//    then sr_clk=1 for CLK_DIV cycles. Duration COLS*2*CLK_DIV cycles.
//    sr_data is stable across each rising edge. Ends with sr_clk=0.
//  LATCH: sr_latch=1 for CLK_DIV cycles; sr_clk=0.
//  DWELL: row_sel = 1<<row for DWELL cycles.
//    Last cycle of row ROWS-1: frame_done=1, then row wraps to 0.
//    Other rows: row+1.
//  row_sel is 0 in LOAD, SHIFT and LATCH, so latch changes never appear on a lit row (anti-ghosting).
//  sr_data=1 whenever not in SHIFT.
//  Row period = 1 + 2*COLS*CLK_DIV + CLK_DIV + DWELL; defaults: 1+64+2+100 = 167 clk.
//    Frame = ROWS*167 = 1336 clk.
//  en deasserted mid-frame: current frame completes; scanner parks in LOAD at row 0.
//  pixelReg changes after the row-0 LOAD snapshot have no effect until the next frame.
//  Counters sized with $clog2; the bit counter counts down from COLS-1 to 0.
//    No counter wraps except row (ROWS-1 -> 0).
//  All outputs are registered.
// STRUCTURE
//  Shared include snake_defs.vh:
//    SNAKE_ROWS=8, SNAKE_COLS=16, PIX_ON=1'b0, PIX_OFF=1'b1, state encodings S_LOAD..S_DWELL.
//  Sub-module sr_serializer: COLS-bit parallel load plus start/busy.
//    Generates sr_data/sr_clk with CLK_DIV timing and asserts done.
//    The FSM, frame buffer and row/dwell counters stay in matrix_scan.
// TESTING (CLK_DIV=2, DWELL=100)
//  1 Reset: hold init 3 cycles -> all outputs at reset values.
//    First sr_clk rise occurs 1+2 cycles after the LOAD cycle.
//  2 pixelReg = all 1s except bit 37 (row 2, col 5) -> row 2's 11th sr_clk rise samples sr_data=0.
//    Its other 15 rises sample 1. row_sel=8'b0000_0100 for exactly 100 cycles.
//    All other rows shift all 1s.
//  3 Tearing: flip pixelReg to all 0s during row 3 SHIFT -> rows 3..7 still shift snapshot data.
//    Next frame's rows shift all 0s.
//  4 en=0 from mid-frame -> frame finishes; row_sel stays 0 and sr_clk idle for 500 cycles.
//    Set en=1 -> row 0 scan starts from LOAD next cycle.
//  5 Free run -> frame_done pulses 1 cycle wide, exactly every 1336 cycles.
//    Never two row_sel bits set; row_sel=0 whenever sr_latch=1.
//  6 Assert init during row 5 SHIFT -> next cycle: sr_clk=0, sr_data=1, row_sel=0.
//    Scan restarts at row 0 with a fresh snapshot.

Source files
------------

// File: rtl/matrix_scan_pkg.sv
// Shared types and constants for the snake LED matrix scanner.
package matrix_scan_pkg;

    localparam int unsigned SNAKE_ROWS = 8;
    localparam int unsigned SNAKE_COLS = 16;

    // Pixel polarity: 0 lights the LED, 1 leaves it dark (active-low column sink).
    localparam logic PIX_OFF = 1'b1;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2,
        S_DWELL = 2'd3
    } scan_state_e;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_scan_sr_serializer.sv
// Shifts one row of column bits MSB first into a 74HC595-style chain.
module matrix_scan_sr_serializer
    import matrix_scan_pkg::*;
#(
    parameter int unsigned COLS    = SNAKE_COLS,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic            clk,
    input  logic            init,
    input  logic            start,
    input  logic [COLS-1:0] din,
    output logic            sr_data,
    output logic            sr_clk,
    output logic            busy,
    output logic            done_c
);

    localparam int unsigned BW = cnt_w(COLS);
    localparam int unsigned DW = cnt_w(CLK_DIV);

    logic            active_q, active_d;
    logic [COLS-1:0] shreg_q, shreg_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DW-1:0]   div_q, div_d;
    logic            sr_clk_q, sr_clk_d;
    logic            sr_data_q, sr_data_d;
    logic            div_end_c;
    logic            last_bit_c;

    assign div_end_c  = (div_q == DW'(CLK_DIV - 1));
    assign last_bit_c = (bit_q == '0);
    // Final cycle of the high half of the last bit.
    assign done_c     = active_q && sr_clk_q && div_end_c && last_bit_c;

    // Bit/phase sequencing: data changes only while sr_clk is low.
    always_comb begin
        active_d  = active_q;
        shreg_d   = shreg_q;
        bit_d     = bit_q;
        div_d     = div_q;
        sr_clk_d  = sr_clk_q;
        sr_data_d = sr_data_q;
        if (start) begin
            active_d  = 1'b1;
            shreg_d   = din;
            bit_d     = BW'(COLS - 1);
            div_d     = '0;
            sr_clk_d  = 1'b0;
            sr_data_d = din[COLS-1];
        end else if (active_q) begin
            if (div_end_c) begin
                div_d = '0;
                if (!sr_clk_q) begin
                    sr_clk_d = 1'b1;
                end else if (last_bit_c) begin
                    active_d  = 1'b0;
                    sr_clk_d  = 1'b0;
                    sr_data_d = PIX_OFF;
                end else begin
                    bit_d     = bit_q - BW'(1);
                    sr_clk_d  = 1'b0;
                    sr_data_d = shreg_q[bit_q - BW'(1)];
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (init) begin
            active_q  <= 1'b0;
            shreg_q   <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            sr_clk_q  <= 1'b0;
            sr_data_q <= PIX_OFF;
        end else begin
            active_q  <= active_d;
            shreg_q   <= shreg_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            sr_clk_q  <= sr_clk_d;
            sr_data_q <= sr_data_d;
        end
    end

    assign sr_data = sr_data_q;
    assign sr_clk  = sr_clk_q;
    assign busy    = active_q;

endmodule

// File: rtl/matrix_scan.sv
// Row-by-row LED matrix refresh from a tear-free snapshot of the pixel register.
module matrix_scan
    import matrix_scan_pkg::*;
#(
    parameter int unsigned ROWS    = SNAKE_ROWS,
    parameter int unsigned COLS    = SNAKE_COLS,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned DWELL   = 100
) (
    input  logic                 clk,
    input  logic                 init,
    input  logic                 en,
    input  logic [ROWS*COLS-1:0] pixelReg,
    output logic                 sr_data,
    output logic                 sr_clk,
    output logic                 sr_latch,
    output logic [ROWS-1:0]      row_sel,
    output logic                 frame_done
);

    localparam int unsigned RW = cnt_w(ROWS);
    localparam int unsigned CW = cnt_w((CLK_DIV > DWELL) ? CLK_DIV : DWELL);

    scan_state_e                 state_q, state_d;
    logic [RW-1:0]               row_q, row_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [ROWS-1:0][COLS-1:0]   fb_q, fb_d;
    logic                        sr_latch_q, sr_latch_d;
    logic [ROWS-1:0]             row_sel_q, row_sel_d;
    logic                        frame_done_q, frame_done_d;
    logic                        start_c;
    logic [COLS-1:0]             ser_din_c;
    logic                        ser_busy;
    logic                        ser_done_c;

    // Row 0 shifts straight from pixelReg on the cycle its snapshot is taken.
    assign ser_din_c = (row_q == '0) ? pixelReg[COLS-1:0] : fb_q[row_q];

    matrix_scan_sr_serializer #(
        .COLS    (COLS),
        .CLK_DIV (CLK_DIV)
    ) u_ser (
        .clk     (clk),
        .init    (init),
        .start   (start_c),
        .din     (ser_din_c),
        .sr_data (sr_data),
        .sr_clk  (sr_clk),
        .busy    (ser_busy),
        .done_c  (ser_done_c)
    );

    // Next state, counters, snapshot and registered-output values.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        cnt_d        = cnt_q;
        fb_d         = fb_q;
        sr_latch_d   = 1'b0;
        row_sel_d    = '0;
        start_c      = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (((row_q != '0) || en) && !ser_busy) begin
                    if (row_q == '0) begin
                        fb_d = pixelReg;
                    end
                    start_c = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ser_done_c) begin
                    state_d    = S_LATCH;
                    sr_latch_d = 1'b1;
                    cnt_d      = CW'(CLK_DIV - 1);
                end
            end
            S_LATCH: begin
                if (cnt_q == '0) begin
                    state_d   = S_DWELL;
                    row_sel_d = ROWS'(1) << row_q;
                    cnt_d     = CW'(DWELL - 1);
                end else begin
                    sr_latch_d = 1'b1;
                    cnt_d      = cnt_q - CW'(1);
                end
            end
            S_DWELL: begin
                if (cnt_q == '0) begin
                    state_d = S_LOAD;
                    row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
                end else begin
                    row_sel_d = ROWS'(1) << row_q;
                    cnt_d     = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
        frame_done_d = (state_d == S_DWELL) && (cnt_d == '0) && (row_q == RW'(ROWS - 1));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (init) begin
            state_q      <= S_LOAD;
            row_q        <= '0;
            cnt_q        <= '0;
            fb_q         <= '1;
            sr_latch_q   <= 1'b0;
            row_sel_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            fb_q         <= fb_d;
            sr_latch_q   <= sr_latch_d;
            row_sel_q    <= row_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sr_latch   = sr_latch_q;
    assign row_sel    = row_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan: per-frame vector tables plus hand-written corner sequences.
module tb_matrix_scan;

    localparam int unsigned ROWS    = 8;
    localparam int unsigned COLS    = 16;
    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned DWELL   = 100;
    localparam int          FRAME   = 1336;

    logic         clk = 1'b0;
    logic         init;
    logic         en;
    logic [127:0] pixelReg;
    logic         sr_data;
    logic         sr_clk;
    logic         sr_latch;
    logic [7:0]   row_sel;
    logic         frame_done;

    always #5 clk = ~clk;

    matrix_scan #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .CLK_DIV (CLK_DIV),
        .DWELL   (DWELL)
    ) dut (
        .clk        (clk),
        .init       (init),
        .en         (en),
        .pixelReg   (pixelReg),
        .sr_data    (sr_data),
        .sr_clk     (sr_clk),
        .sr_latch   (sr_latch),
        .row_sel    (row_sel),
        .frame_done (frame_done)
    );

    // One record per frame: pixel input and the 16-bit word each row must shift.
    typedef struct packed {
        logic [127:0]     pix;
        logic [7:0][15:0] words;
    } frame_vec_t;

    frame_vec_t vecs [4];
    int n_vec = 0;
    int n_bad = 0;

    // Monitor state (written only by the monitor process).
    int         cyc = 0;
    logic       prev_clk = 1'b0;
    logic       prev_latch = 1'b0;
    logic       prev_fd = 1'b0;
    logic [15:0] shift_word = '1;
    logic [15:0] latched_word = '1;
    int         rise_cnt = 0;
    int         latched_rises = 0;
    int         dwell_cnt = 0;
    int         cur_row = 0;
    logic [7:0] cur_sel = '0;
    logic [15:0] got_word [8];
    logic [7:0] got_sel [8];
    int         got_dwell [8];
    int         got_rises [8];
    int         got_stamp [8];
    int         fd_count = 0;
    int         fd_last = 0;
    int         fd_period = 0;
    int         inv_err = 0;

    // Reconstruct each row from the chain's point of view and track invariants.
    always @(negedge clk) begin
        cyc++;
        if (init) begin
            rise_cnt   = 0;
            shift_word = '1;
            dwell_cnt  = 0;
        end else begin
            if (sr_clk && !prev_clk) begin
                shift_word = {shift_word[14:0], sr_data};
                rise_cnt++;
            end
            if (sr_latch && !prev_latch) begin
                latched_word  = shift_word;
                latched_rises = rise_cnt;
                rise_cnt      = 0;
            end
            if (row_sel != 8'h00) begin
                if (dwell_cnt == 0) begin
                    cur_sel = row_sel;
                    for (int i = 0; i < 8; i++) if (row_sel[i]) cur_row = i;
                    got_stamp[cur_row] = fd_count;
                end else if (row_sel != cur_sel) begin
                    inv_err++;
                end
                dwell_cnt++;
            end else if (dwell_cnt != 0) begin
                got_dwell[cur_row] = dwell_cnt;
                got_word[cur_row]  = latched_word;
                got_rises[cur_row] = latched_rises;
                got_sel[cur_row]   = cur_sel;
                dwell_cnt = 0;
            end
        end
        if ($countones(row_sel) > 1) inv_err++;
        if (sr_latch && ((row_sel != 8'h00) || sr_clk)) inv_err++;
        if (frame_done && prev_fd) inv_err++;
        if (frame_done && (row_sel != 8'h80)) inv_err++;
        if (frame_done) begin
            fd_count++;
            fd_period = cyc - fd_last;
            fd_last   = cyc;
        end
        prev_clk   = sr_clk;
        prev_latch = sr_latch;
        prev_fd    = frame_done;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_fd(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: frame_done never seen within %0d cycles", tag, k);
        end
    endtask

    task automatic wait_sel(input logic [7:0] target, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (row_sel !== target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (row_sel !== target) begin
            n_bad++;
            $display("FAIL %s: row_sel got %0h expected %0h (timeout)", tag, row_sel, target);
        end
    endtask

    // Cycles from the driving negedge to the first visible sr_clk high.
    task automatic first_rise(input logic exp_bit, input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (sr_clk !== 1'b1 && k < 20);
        chk({tag, "_first_rise_delay"}, 32'(k), 32'd3);
        chk({tag, "_first_bit"}, {31'd0, sr_data}, {31'd0, exp_bit});
    endtask

    // Compare every row of the frame just completed against table entry vi.
    task automatic check_frame(input int vi, input string tag);
        repeat (3) @(negedge clk);
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("%s_row%0d_word", tag, r), {16'd0, got_word[r]}, {16'd0, vecs[vi].words[r]});
            chk($sformatf("%s_row%0d_sel", tag, r), {24'd0, got_sel[r]}, {24'd0, 8'(1 << r)});
            chk($sformatf("%s_row%0d_dwell", tag, r), 32'(got_dwell[r]), 32'(DWELL));
            chk($sformatf("%s_row%0d_rises", tag, r), 32'(got_rises[r]), 32'(COLS));
            chk($sformatf("%s_row%0d_stamp", tag, r), 32'(got_stamp[r]), 32'(fd_count - 1));
        end
    endtask

    initial begin
        int act;
        vecs[0].pix   = ~(128'd1 << 37);
        vecs[0].words = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFDF, 16'hFFFF, 16'hFFFF};
        vecs[1].pix   = '0;
        vecs[1].words = '0;
        vecs[2].pix   = {{7{16'hFFFF}}, 16'h5AC3};
        vecs[2].words = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h5AC3};
        vecs[3].pix   = {{2{16'hFFFF}}, 16'h0F0F, {4{16'hFFFF}}, 16'h1234};
        vecs[3].words = {16'hFFFF, 16'hFFFF, 16'h0F0F, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1234};

        // Reset held for three edges.
        init     = 1'b1;
        en       = 1'b0;
        pixelReg = vecs[0].pix;
        repeat (3) @(negedge clk);
        chk("rst_sr_data", {31'd0, sr_data}, 32'd1);
        chk("rst_sr_clk", {31'd0, sr_clk}, 32'd0);
        chk("rst_sr_latch", {31'd0, sr_latch}, 32'd0);
        chk("rst_row_sel", {24'd0, row_sel}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);

        // Single dark-to-lit pixel at row 2 col 5.
        init = 1'b0;
        en   = 1'b1;
        first_rise(1'b1, "f1");
        wait_fd("f1");
        check_frame(0, "f1");

        // Tearing: pixelReg flips to zeros during row 3 shift.
        wait_sel(8'h04, "f2_row2");
        wait_sel(8'h00, "f2_row3_load");
        repeat (10) @(negedge clk);
        pixelReg = '0;
        wait_fd("f2");
        check_frame(0, "f2");
        wait_fd("f3");
        check_frame(1, "f3");
        chk("frame_period", 32'(fd_period), 32'(FRAME));

        // Enable dropped mid-frame: frame completes, then scanner parks.
        repeat (300) @(negedge clk);
        en = 1'b0;
        wait_fd("f4");
        check_frame(1, "f4");
        act = 0;
        repeat (500) begin
            @(negedge clk);
            if (row_sel != 8'h00 || sr_clk || sr_latch) act++;
        end
        chk("parked_activity", 32'(act), 32'd0);
        pixelReg = vecs[2].pix;
        en       = 1'b1;
        first_rise(1'b0, "f5");
        wait_fd("f5");
        check_frame(2, "f5");

        // Reset during row 5 shift, then a fresh frame.
        wait_sel(8'h10, "f6_row4");
        wait_sel(8'h00, "f6_row5_load");
        repeat (5) @(negedge clk);
        pixelReg = vecs[3].pix;
        init     = 1'b1;
        @(negedge clk);
        chk("midrst_sr_clk", {31'd0, sr_clk}, 32'd0);
        chk("midrst_sr_data", {31'd0, sr_data}, 32'd1);
        chk("midrst_row_sel", {24'd0, row_sel}, 32'd0);
        chk("midrst_sr_latch", {31'd0, sr_latch}, 32'd0);
        init = 1'b0;
        first_rise(1'b0, "f7");
        wait_fd("f7");
        check_frame(3, "f7");

        chk("invariant_violations", 32'(inv_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
